mmu_q: RTL and testbench
========================

# mmu_q

Parametrised sample-memory manager for logIP capture storage, successor to the single-pointer stack manager. It owns one dual-port RAM of 2**DEPTH words and runs in one of three runtime-selectable modes:

- LIFO stack
- FIFO queue
- RING buffer, which overwrites the oldest sample when full (pre-trigger capture)

It reports occupancy, full and empty status, and sticky error flags, and delivers read data with a valid strobe. It sits between the sampler/trigger path and the readout/UART transmitter.

## Interface
- WIDTH, 32, sample word width in bits
- DEPTH, 5, address width; capacity is N = 2**DEPTH words
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- mode_i  in  2  mode select (mmu_mode_t); latched only at reset or clr_i
- clr_i  in  1  synchronous clear: empties the store, clears error flags, latches mode_i
- wrt_i  in  1  write request
- read_i  in  1  read request
- d_i  in  WIDTH  write data
- q_o  out  WIDTH  read data; reset 0; holds its last value between reads
- valid_o  out  1  one-cycle strobe marking new q_o; reset 0
- count_o  out  DEPTH+1  stored word count, 0..N; reset 0
- full_o  out  1  count_o == N; reset 0
- empty_o  out  1  count_o == 0; reset 1
- ovf_o  out  1  sticky: a write was dropped; reset 0
- udf_o  out  1  sticky: a read was made while empty; reset 0

## Operation
- Mode register: reset value is MMU_LIFO. It loads mode_i on rst_i, or on clr_i when rst_i is low. Code 2'b11 is reserved and decodes as LIFO.
- Priority: rst_i, then clr_i, then wrt_i/read_i. Requests in a clr_i cycle are ignored.
- LIFO, single pointer sp:
  - Write stores at sp; sp+1.
  - Read fetches sp-1; sp-1.
  - Read and write together, when not empty: the RAM reads first, so q_o returns the old top. The top is replaced by d_i. sp and count are unchanged.
  - Read and write together, when empty: the read is rejected (udf_o set) and the write is accepted.
- FIFO, pointers wp and rp:
  - Write stores at wp; wp+1.
  - Read fetches rp; rp+1.
  - Read and write together: both are accepted if the store is not empty and the write is legal; count is unchanged.
  - When empty, the read is rejected and there is no bypass.
  - When full, read and write together: both are accepted.
- RING: same as FIFO, except a write when full is always accepted.
  - On such a write, rp advances with wp and count stays at N.
  - ovf_o is not set.
  - Full, read and write together: q_o returns the oldest word, rp+1, wp+1, count N.
- Rejections:
  - Write when full in LIFO/FIFO: dropped; ovf_o set to 1.
  - Read when empty in any mode: ignored; valid_o stays 0; udf_o set to 1.
- All pointers wrap modulo N. count_o is tracked separately, so full (N) and empty (0) are unambiguous.

## Timing
- An accepted read returns q_o with valid_o=1 exactly 1 cycle after the request edge. Throughput is one read per cycle.
- count_o, full_o, empty_o, ovf_o and udf_o are registered. They reflect the store state after each edge, with no extra latency.
- A written word is readable by a read request in the next cycle.
- clr_i or rst_i asserted the cycle after an accepted read:
  - valid_o is forced to 0 on the following edge, so the in-flight read is suppressed.
  - q_o keeps its old value on clr_i and goes to 0 on rst_i.
- wrt_i and read_i are level-sampled on every edge with no handshake. A request held high for k cycles performs k operations.

## Structure
- logIP_pkg holds:
  - typedef enum logic [1:0] mmu_mode_t {MMU_LIFO=2'b00, MMU_FIFO=2'b01, MMU_RING=2'b10}
  - the reserved-code note
- Sub-module ram_dp (WIDTH, DEPTH): write port and read port on clk_i, read-first on an address collision, registered read data, no reset on the array.
- mmu_q contains the mode register, pointer and count logic, and flag registers. It contains no FSM beyond the mode register.

## Test plan
Bench uses DEPTH=2 (N=4), WIDTH=8.
- FIFO: write 11, 22, 33, 44 → full_o=1, count_o=4. Write 55 → ovf_o=1, count_o=4. Four reads → q_o 11, 22, 33, 44, each with valid_o 1 cycle later; then empty_o=1.
- LIFO: write A1, A2, A3, then read+write B4 in one cycle → q_o=A3, count_o=3. Three reads → B4, A2, A1.
- RING: write 01..06 → count_o=4, ovf_o=0. Reads → 03, 04, 05, 06.
- Empty read, any mode → valid_o=0, udf_o=1. clr_i → udf_o=0, empty_o=1, and a new mode_i takes effect.
- FIFO read+write every cycle for 10 cycles from count 2 → count_o stays 2, data stays in order across pointer wrap.
- rst_i the cycle after a read → valid_o=0, q_o=0, count_o=0, mode LIFO.

Source files
------------

// File: rtl/logIP_pkg.sv
// Shared types for the logIP capture-storage blocks.
// Mode code 2'b11 is reserved and decodes as MMU_LIFO.
package logIP_pkg;

  typedef enum logic [1:0] {
    MMU_LIFO = 2'b00,
    MMU_FIFO = 2'b01,
    MMU_RING = 2'b10
  } mmu_mode_t;

  function automatic mmu_mode_t mode_decode(input logic [1:0] code);
    case (code)
      2'b01:   return MMU_FIFO;
      2'b10:   return MMU_RING;
      default: return MMU_LIFO;
    endcase
  endfunction

endpackage

// File: rtl/ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on collision.
module ram_dp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk_i,
  input  logic             wr_en,
  input  logic [DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH];

  always_ff @(posedge clk_i) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/mmu_q.sv
// Sample-memory manager: LIFO / FIFO / RING over one dual-port RAM,
// with occupancy, full/empty status and sticky overflow/underflow flags.
module mmu_q
  import logIP_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  input  logic             wrt_i,
  input  logic             read_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic [DEPTH:0]   count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam logic [DEPTH:0] CAP = (DEPTH+1)'(2**DEPTH);

  mmu_mode_t        mode_q;
  logic [DEPTH-1:0] sp, wp, rp;
  logic [DEPTH-1:0] wr_addr, rd_addr;
  logic [DEPTH:0]   count_nxt;
  logic [WIDTH-1:0] ram_rd, q_hold;
  logic             go, rd_ok, wr_ok, overwrite, valid_q;

  always_comb begin
    go        = !rst_i && !clr_i;
    rd_ok     = go && read_i && !empty_o;
    wr_ok     = go && wrt_i && (mode_q == MMU_RING || !full_o || rd_ok);
    // RING write into a full store with no read pushes out the oldest word
    overwrite = wr_ok && full_o && !rd_ok;

    if (mode_q == MMU_LIFO) begin
      rd_addr = sp - DEPTH'(1);
      wr_addr = rd_ok ? sp - DEPTH'(1) : sp;
    end else begin
      rd_addr = rp;
      wr_addr = wp;
    end

    count_nxt = count_o;
    if (wr_ok && !rd_ok && !overwrite) count_nxt = count_o + (DEPTH+1)'(1);
    else if (rd_ok && !wr_ok)          count_nxt = count_o - (DEPTH+1)'(1);
  end

  ram_dp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (d_i),
    .rd_en   (rd_ok),
    .rd_addr (rd_addr),
    .rd_data (ram_rd)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      mode_q  <= mode_decode(mode_i);
      sp      <= '0;
      wp      <= '0;
      rp      <= '0;
      count_o <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
      ovf_o   <= 1'b0;
      udf_o   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (mode_q == MMU_LIFO) begin
        if (wr_ok && !rd_ok)      sp <= sp + DEPTH'(1);
        else if (rd_ok && !wr_ok) sp <= sp - DEPTH'(1);
      end else begin
        if (wr_ok)                 wp <= wp + DEPTH'(1);
        if (rd_ok || overwrite)    rp <= rp + DEPTH'(1);
      end
      count_o <= count_nxt;
      full_o  <= (count_nxt == CAP);
      empty_o <= (count_nxt == '0);
      if (wrt_i && !wr_ok)     ovf_o <= 1'b1;
      if (read_i && empty_o)   udf_o <= 1'b1;
      valid_q <= rd_ok;
    end
  end

  // q_o shows fresh RAM data in the valid cycle and the captured copy afterwards
  always_ff @(posedge clk_i) begin
    if (rst_i)        q_hold <= '0;
    else if (valid_q) q_hold <= ram_rd;
  end

  assign valid_o = valid_q;
  assign q_o     = valid_q ? ram_rd : q_hold;

endmodule

// File: tb/tb_mmu_q.sv
// Randomised and directed checks of mmu_q against a queue-based storage model.
module tb_mmu_q;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, clr, wrt, rd;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q_o;
  logic         valid_o, full_o, empty_o, ovf_o, udf_o;
  logic [D:0]   count_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  int           m_mode;
  logic [W-1:0] m_q;
  logic         m_valid, m_ovf, m_udf;

  mmu_q #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .clr_i(clr), .wrt_i(wrt),
    .read_i(rd), .d_i(d), .q_o(q_o), .valid_o(valid_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {q_o, valid_o, count_o, full_o, empty_o, ovf_o, udf_o};
  endfunction

  function automatic logic [15:0] expv();
    return {m_q, m_valid, 3'(mq.size()), mq.size() == N, mq.size() == 0, m_ovf, m_udf};
  endfunction

  // drive one cycle and advance the storage model by the same edge
  task automatic cyc(input logic r, input logic c, input logic w, input logic rr,
                     input logic [1:0] md, input logic [W-1:0] dd);
    logic can_rd;
    @(negedge clk);
    rst = r; clr = c; wrt = w; rd = rr; mode = md; d = dd;
    @(posedge clk);
    m_valid = 1'b0;
    if (r || c) begin
      mq.delete();
      m_mode = (md == 2'b11) ? 0 : int'(md);
      m_ovf = 1'b0;
      m_udf = 1'b0;
      if (r) m_q = '0;
    end else begin
      can_rd = rr && (mq.size() > 0);
      if (rr && !can_rd) m_udf = 1'b1;
      if (m_mode == 0) begin
        if (can_rd) begin
          m_q = mq[mq.size()-1];
          m_valid = 1'b1;
          if (w) mq[mq.size()-1] = dd;
          else void'(mq.pop_back());
        end else if (w) begin
          if (mq.size() < N) mq.push_back(dd);
          else m_ovf = 1'b1;
        end
      end else begin
        if (can_rd) begin
          m_q = mq.pop_front();
          m_valid = 1'b1;
        end
        if (w) begin
          if (mq.size() < N) mq.push_back(dd);
          else if (m_mode == 2) begin
            void'(mq.pop_front());
            mq.push_back(dd);
          end else m_ovf = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 2'b00, 8'h00);
    cyc(1, 0, 0, 0, 2'b00, 8'h00);
    checks++;
    if (obs() !== 16'h0004) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs(), 16'h0004);
    end
  endtask

  task automatic test_fifo();
    logic [W-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    cyc(0, 1, 0, 0, 2'b01, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 2'b00, vals[i]);
    checks++;
    if (count_o !== 3'd4 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full got count %0d full %b want 4 1", count_o, full_o);
    end
    cyc(0, 0, 1, 0, 2'b00, 8'h55);
    checks++;
    if (ovf_o !== 1'b1 || count_o !== 3'd4) begin
      errors++;
      $display("FAIL fifo_ovf got ovf %b count %0d want 1 4", ovf_o, count_o);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 2'b00, 8'h00);
      checks++;
      if (q_o !== vals[i] || valid_o !== 1'b1 || obs() !== expv()) begin
        errors++;
        $display("FAIL fifo_read%0d got %h want %h (q %h)", i, obs(), expv(), vals[i]);
      end
    end
    checks++;
    if (empty_o !== 1'b1) begin
      errors++;
      $display("FAIL fifo_empty got %b want 1", empty_o);
    end
  endtask

  task automatic test_lifo();
    logic [W-1:0] exp_rd [3] = '{8'hB4, 8'hA2, 8'hA1};
    cyc(0, 1, 0, 0, 2'b00, 8'h00);
    cyc(0, 0, 1, 0, 2'b00, 8'hA1);
    cyc(0, 0, 1, 0, 2'b00, 8'hA2);
    cyc(0, 0, 1, 0, 2'b00, 8'hA3);
    cyc(0, 0, 1, 1, 2'b00, 8'hB4);
    checks++;
    if (q_o !== 8'hA3 || valid_o !== 1'b1 || count_o !== 3'd3) begin
      errors++;
      $display("FAIL lifo_rw got q %h v %b count %0d want a3 1 3", q_o, valid_o, count_o);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 2'b00, 8'h00);
      checks++;
      if (q_o !== exp_rd[i] || obs() !== expv()) begin
        errors++;
        $display("FAIL lifo_read%0d got %h want %h (q %h)", i, obs(), expv(), exp_rd[i]);
      end
    end
  endtask

  task automatic test_ring();
    cyc(0, 1, 0, 0, 2'b10, 8'h00);
    for (int i = 1; i <= 6; i++) cyc(0, 0, 1, 0, 2'b00, 8'(i));
    checks++;
    if (count_o !== 3'd4 || ovf_o !== 1'b0 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL ring_fill got count %0d ovf %b want 4 0", count_o, ovf_o);
    end
    for (int i = 3; i <= 6; i++) begin
      cyc(0, 0, 0, 1, 2'b00, 8'h00);
      checks++;
      if (q_o !== 8'(i) || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL ring_read got %h want %h", q_o, 8'(i));
      end
    end
  endtask

  task automatic test_underflow();
    for (int m = 0; m < 3; m++) begin
      cyc(0, 1, 0, 0, 2'(m), 8'h00);
      cyc(0, 0, 0, 1, 2'b00, 8'h00);
      checks++;
      if (valid_o !== 1'b0 || udf_o !== 1'b1) begin
        errors++;
        $display("FAIL udf_mode%0d got v %b udf %b want 0 1", m, valid_o, udf_o);
      end
    end
    cyc(0, 1, 0, 0, 2'b01, 8'h00);
    checks++;
    if (udf_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL udf_clear got udf %b empty %b want 0 1", udf_o, empty_o);
    end
    cyc(0, 0, 1, 0, 2'b00, 8'h05);
    cyc(0, 0, 1, 0, 2'b00, 8'h06);
    cyc(0, 0, 0, 1, 2'b00, 8'h00);
    checks++;
    if (q_o !== 8'h05) begin
      errors++;
      $display("FAIL clr_mode got %h want 05", q_o);
    end
  endtask

  task automatic test_back_to_back();
    cyc(0, 1, 0, 0, 2'b01, 8'h00);
    cyc(0, 0, 1, 0, 2'b00, 8'h80);
    cyc(0, 0, 1, 0, 2'b00, 8'h81);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 1, 1, 2'b00, 8'(8'h82 + k));
      checks++;
      if (count_o !== 3'd2 || q_o !== 8'(8'h80 + k) || obs() !== expv()) begin
        errors++;
        $display("FAIL b2b_%0d got %h want %h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0)
        cyc(0, 1, 0, 0, 2'($urandom_range(0, 3)), 8'h00);
      else
        cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 8'($urandom));
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random_%0d got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_rst_after_read();
    cyc(0, 1, 0, 0, 2'b10, 8'h00);
    cyc(0, 0, 1, 0, 2'b00, 8'h3C);
    cyc(0, 0, 1, 0, 2'b00, 8'h3D);
    cyc(0, 0, 0, 1, 2'b00, 8'h00);
    cyc(1, 0, 0, 0, 2'b00, 8'h00);
    checks++;
    if (valid_o !== 1'b0 || q_o !== 8'h00 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL rst_after_read got v %b q %h count %0d want 0 00 0", valid_o, q_o, count_o);
    end
    cyc(0, 0, 1, 0, 2'b00, 8'h71);
    cyc(0, 0, 1, 0, 2'b00, 8'h72);
    cyc(0, 0, 0, 1, 2'b00, 8'h00);
    checks++;
    if (q_o !== 8'h72) begin
      errors++;
      $display("FAIL rst_mode_lifo got %h want 72", q_o);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wrt = 1'b0; rd = 1'b0; mode = 2'b00; d = '0;
    m_mode = 0; m_q = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    test_reset();
    test_fifo();
    test_lifo();
    test_ring();
    test_underflow();
    test_back_to_back();
    test_random();
    test_rst_after_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
